// File: rtl/tsp16_pkg.sv
// Shared types and field positions for the TSP16 decode stage.
// Instruction layout: [15:12] opcode, [11:9] rd, [8:6] rm, [5:3] rn, low bits immediate.
package tsp16_pkg;

    localparam int XLEN     = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);

    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RM_LSB   = 6;
    localparam int RN_LSB   = 3;
    localparam int IMM6_W   = 6;
    localparam int IMM9_W   = 9;
    localparam int IMM12_W  = 12;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_MOVI = 4'h4,
        OP_LDR  = 4'h5,
        OP_STR  = 4'h6,
        OP_B    = 4'h7,
        OP_CMP  = 4'h8,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef logic [REG_W-1:0] reg_num_t;

    typedef struct packed {
        logic writes_rd;
        logic uses_rm;
        logic uses_rn;
        logic illegal;
    } usage_t;

    // opcode kept as raw bits so undefined encodings 9..E survive to execute
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [3:0]      opcode;
        reg_num_t        rd;
        reg_num_t        rm;
        reg_num_t        rn;
        logic [XLEN-1:0] imm;
        usage_t          flags;
    } decoded_instr_t;

endpackage

// File: rtl/pipeline_decode_if.sv
// Fetch / execute / writeback signal bundle around the decode stage.
// slave is the decode side, master is whoever drives fetch and consumes decode output.
interface pipeline_decode_if;
    import tsp16_pkg::*;

    logic                 fetch_valid;
    logic [XLEN-1:0]      fetch_instr;
    logic [XLEN-1:0]      fetch_pc;
    logic                 decode_ready;
    logic                 stall_decode;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_instr;
    logic [3:0]           out_opcode;
    logic [REG_W-1:0]     out_rd;
    logic [REG_W-1:0]     rm_num;
    logic [REG_W-1:0]     rn_num;
    logic [XLEN-1:0]      out_imm;
    logic                 out_writes_rd;
    logic                 out_uses_rm;
    logic                 out_uses_rn;
    logic                 out_illegal;
    logic                 writeback_write;
    logic [REG_W-1:0]     writeback_writenum;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, flush, out_ready,
               writeback_write, writeback_writenum,
        input  decode_ready, stall_decode, out_valid, out_pc, out_instr,
               out_opcode, out_rd, rm_num, rn_num, out_imm,
               out_writes_rd, out_uses_rm, out_uses_rn, out_illegal
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, flush, out_ready,
               writeback_write, writeback_writenum,
        output decode_ready, stall_decode, out_valid, out_pc, out_instr,
               out_opcode, out_rd, rm_num, rn_num, out_imm,
               out_writes_rd, out_uses_rm, out_uses_rn, out_illegal
    );

endinterface

// File: rtl/decode_scoreboard.sv
// Per-register busy bits for instructions past decode, plus the RAW/WAW hazard query
// for the instruction currently offered by fetch.
module decode_scoreboard
    import tsp16_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  reg_num_t set_num,
    input  logic     clr_en,
    input  reg_num_t clr_num,
    input  logic     held_busy,
    input  reg_num_t held_num,
    input  logic     q_writes_rd,
    input  logic     q_uses_rm,
    input  logic     q_uses_rn,
    input  reg_num_t q_rd,
    input  reg_num_t q_rm,
    input  reg_num_t q_rn,
    output logic     hazard
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] in_flight;

    // set after clear so a same-cycle set/clear of one register leaves it busy
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_num] = 1'b0;
        if (set_en) busy_d[set_num] = 1'b1;
    end

    // retiring register counts as free (bypass); the held output stage counts as a writer
    always_comb begin
        in_flight = busy_q;
        if (clr_en)    in_flight[clr_num]  = 1'b0;
        if (held_busy) in_flight[held_num] = 1'b1;
    end

    assign hazard = (q_writes_rd && in_flight[q_rd])
                 || (q_uses_rm   && in_flight[q_rm])
                 || (q_uses_rn   && in_flight[q_rn]);

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/pipeline_decode.sv
// TSP16 decode stage: field split and sign extension, hazard stall against in-flight
// writers, and a single registered output slot toward execute.
module pipeline_decode
    import tsp16_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    pipeline_decode_if.slave bus
);

    decoded_instr_t dec;
    decoded_instr_t held_q;
    logic           held_valid_q;
    logic           hazard;
    logic           accept;
    logic           consume;

    always_comb begin
        dec        = '0;
        dec.pc     = bus.fetch_pc;
        dec.instr  = bus.fetch_instr;
        dec.opcode = bus.fetch_instr[OPC_LSB +: 4];
        dec.rd     = bus.fetch_instr[RD_LSB +: REG_W];
        dec.rm     = bus.fetch_instr[RM_LSB +: REG_W];
        dec.rn     = bus.fetch_instr[RN_LSB +: REG_W];
        case (bus.fetch_instr[OPC_LSB +: 4])
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.flags.writes_rd = 1'b1;
                dec.flags.uses_rm   = 1'b1;
                dec.flags.uses_rn   = 1'b1;
            end
            OP_MOVI: begin
                dec.flags.writes_rd = 1'b1;
                dec.imm = {{(XLEN-IMM9_W){bus.fetch_instr[IMM9_W-1]}},
                           bus.fetch_instr[IMM9_W-1:0]};
            end
            OP_LDR: begin
                dec.flags.writes_rd = 1'b1;
                dec.flags.uses_rm   = 1'b1;
                dec.imm = {{(XLEN-IMM6_W){bus.fetch_instr[IMM6_W-1]}},
                           bus.fetch_instr[IMM6_W-1:0]};
            end
            OP_STR: begin
                dec.flags.uses_rm = 1'b1;
                dec.flags.uses_rn = 1'b1;
                dec.imm = {{(XLEN-IMM6_W){bus.fetch_instr[IMM6_W-1]}},
                           bus.fetch_instr[IMM6_W-1:0]};
            end
            OP_B: begin
                dec.imm = {{(XLEN-IMM12_W){bus.fetch_instr[IMM12_W-1]}},
                           bus.fetch_instr[IMM12_W-1:0]};
            end
            OP_CMP: begin
                dec.flags.uses_rm = 1'b1;
                dec.flags.uses_rn = 1'b1;
            end
            OP_NOP: ;
            default: dec.flags.illegal = 1'b1;
        endcase
    end

    decode_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (consume && held_q.flags.writes_rd),
        .set_num     (held_q.rd),
        .clr_en      (bus.writeback_write),
        .clr_num     (bus.writeback_writenum),
        .held_busy   (held_valid_q && held_q.flags.writes_rd && !bus.flush),
        .held_num    (held_q.rd),
        .q_writes_rd (dec.flags.writes_rd),
        .q_uses_rm   (dec.flags.uses_rm),
        .q_uses_rn   (dec.flags.uses_rn),
        .q_rd        (dec.rd),
        .q_rm        (dec.rm),
        .q_rn        (dec.rn),
        .hazard      (hazard)
    );

    assign bus.decode_ready = !reset && !bus.flush && !hazard && (!held_valid_q || bus.out_ready);
    assign bus.stall_decode = !reset && bus.fetch_valid && hazard;
    assign accept           = bus.fetch_valid && bus.decode_ready;
    assign consume          = held_valid_q && bus.out_ready && !bus.flush;

    // a flushed instruction just disappears; it never reaches the busy vector
    always_ff @(posedge clk) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_q       <= '0;
        end else if (accept) begin
            held_valid_q <= 1'b1;
            held_q       <= dec;
        end else if (bus.flush || bus.out_ready) begin
            held_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = held_valid_q;
    assign bus.out_pc        = held_q.pc;
    assign bus.out_instr     = held_q.instr;
    assign bus.out_opcode    = held_q.opcode;
    assign bus.out_rd        = held_q.rd;
    assign bus.rm_num        = held_q.rm;
    assign bus.rn_num        = held_q.rn;
    assign bus.out_imm       = held_q.imm;
    assign bus.out_writes_rd = held_q.flags.writes_rd;
    assign bus.out_uses_rm   = held_q.flags.uses_rm;
    assign bus.out_uses_rn   = held_q.flags.uses_rn;
    assign bus.out_illegal   = held_q.flags.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Scoreboard bench for pipeline_decode: directed scenarios followed by random traffic,
// with expectations from an instruction-level model of the decode stage.
module tb_pipeline_decode;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [3:0]  op;
        logic [2:0]  rd, rm, rn;
        logic [15:0] imm;
        bit          wr, um, un, ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    pipeline_decode_if bus();

    pipeline_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    exp_t exp_q[$];

    // model state: which registers have a writer past decode, and what sits in the output slot
    bit          m_busy [8];
    bit          m_hv, m_hwr;
    logic [2:0]  m_hrd;
    bit          pend_valid;
    exp_t        pend_exp;
    logic [15:0] pc_ctr = 16'h0100;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input int v, input int bits);
        int r = v;
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return r[15:0];
    endfunction

    function automatic exp_t model_decode(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        int   op = int'(ins[15:12]);
        int   raw = int'(ins);
        e.pc = pc; e.instr = ins; e.op = ins[15:12];
        e.rd = ins[11:9]; e.rm = ins[8:6]; e.rn = ins[5:3];
        e.imm = 16'h0; e.wr = 0; e.um = 0; e.un = 0; e.ill = 0;
        if (op <= 3) begin e.wr = 1; e.um = 1; e.un = 1; end
        else if (op == 4) begin e.wr = 1; e.imm = sext(raw % 512, 9); end
        else if (op == 5) begin e.wr = 1; e.um = 1; e.imm = sext(raw % 64, 6); end
        else if (op == 6) begin e.um = 1; e.un = 1; e.imm = sext(raw % 64, 6); end
        else if (op == 7) e.imm = sext(raw % 4096, 12);
        else if (op == 8) begin e.um = 1; e.un = 1; end
        else if (op != 15) e.ill = 1;
        return e;
    endfunction

    function automatic logic [64:0] exp_vec(input exp_t e);
        return {e.pc, e.instr, e.op, e.rd, e.rm, e.rn, e.imm, e.wr, e.um, e.un, e.ill};
    endfunction

    function automatic logic [64:0] dut_vec();
        return {bus.out_pc, bus.out_instr, bus.out_opcode, bus.out_rd, bus.rm_num, bus.rn_num,
                bus.out_imm, bus.out_writes_rd, bus.out_uses_rm, bus.out_uses_rn, bus.out_illegal};
    endfunction

    function automatic bit in_flight(input logic [2:0] r, input bit wb, input logic [2:0] wbn,
                                     input bit fl);
        return (m_busy[r] && !(wb && wbn == r)) || (m_hv && m_hwr && m_hrd == r && !fl);
    endfunction

    // one clock of stimulus; model predicts handshake outputs and the next model state
    task automatic cyc(input bit fv, input logic [15:0] ins, input bit ordy, input bit fl,
                       input bit wb, input logic [2:0] wbn, input bit rst);
        exp_t d;
        bit   hz, exp_ready, exp_stall, acc, cons;
        @(posedge clk);
        if (pend_valid) begin
            exp_q.push_back(pend_exp);
            pend_valid = 0;
        end
        #1;
        reset                  = rst;
        bus.fetch_valid        = fv;
        bus.fetch_instr        = ins;
        bus.fetch_pc           = pc_ctr;
        bus.out_ready          = ordy;
        bus.flush              = fl;
        bus.writeback_write    = wb;
        bus.writeback_writenum = wbn;
        #2;
        d  = model_decode(ins, pc_ctr);
        hz = (d.wr && in_flight(d.rd, wb, wbn, fl)) || (d.um && in_flight(d.rm, wb, wbn, fl))
          || (d.un && in_flight(d.rn, wb, wbn, fl));
        exp_ready = !rst && !fl && !hz && (!m_hv || ordy);
        exp_stall = !rst && fv && hz;
        chk("decode_ready", bus.decode_ready, exp_ready);
        chk("stall_decode", bus.stall_decode, exp_stall);
        acc  = fv && exp_ready;
        cons = m_hv && ordy && !fl;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_hv = 0;
        end else begin
            if (wb) m_busy[wbn] = 0;
            if (cons && m_hwr) m_busy[m_hrd] = 1;
            if (acc) begin
                m_hv = 1; m_hrd = d.rd; m_hwr = d.wr;
                pend_exp = d; pend_valid = 1;
            end else if (fl || ordy) begin
                m_hv = 0;
            end
        end
        if (acc) pc_ctr = pc_ctr + 16'd2;
    endtask

    task automatic idle(input bit ordy, input bit wb, input logic [2:0] wbn);
        cyc(0, 16'hF000, ordy, 0, wb, wbn, 0);
    endtask

    // monitor: every held instruction must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("out_valid", bus.out_valid, exp_q.size() > 0);
                if (bus.out_valid && exp_q.size() > 0)
                    chk("out_fields", dut_vec(), exp_vec(exp_q[0]));
                if (reset) exp_q.delete();
                else if (exp_q.size() > 0 && (bus.flush || bus.out_ready)) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] ins;
        logic [2:0]  r [3];
        reset = 1'b1;
        bus.fetch_valid = 0; bus.fetch_instr = 16'h0; bus.fetch_pc = 16'h0;
        bus.out_ready = 0; bus.flush = 0; bus.writeback_write = 0; bus.writeback_writenum = 0;

        cyc(0, 16'h0000, 0, 0, 0, 0, 1);
        cyc(0, 16'h0000, 0, 0, 0, 0, 1);
        chk("rst_fields", dut_vec(), 65'h0);
        chk("rst_valid", bus.out_valid, 0);

        // independent ADD stream at full rate
        cyc(1, 16'h0298, 1, 0, 0, 0, 0);
        cyc(1, 16'h0898, 1, 0, 0, 0, 0);
        chk("add_rd", {bus.out_rd, bus.rm_num, bus.rn_num}, {3'd1, 3'd2, 3'd3});
        cyc(1, 16'h0A98, 1, 0, 0, 0, 0);
        chk("stream_ready", bus.decode_ready, 1);
        cyc(1, 16'h0C98, 1, 0, 0, 0, 0);
        idle(1, 1, 3'd1); idle(1, 1, 3'd4); idle(1, 1, 3'd5); idle(1, 1, 3'd6);

        // RAW on r1 released by writeback bypass
        cyc(1, 16'h0298, 1, 0, 0, 0, 0);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        chk("raw_stall_held", bus.stall_decode, 1);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        chk("raw_stall_busy", bus.stall_decode, 1);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        cyc(1, 16'h1850, 1, 0, 1, 3'd1, 0);
        chk("raw_bypass_ready", bus.decode_ready, 1);
        idle(1, 0, 0); idle(1, 1, 3'd4);

        // immediate sign extension
        cyc(1, 16'h45FF, 1, 0, 0, 0, 0);
        cyc(1, 16'h5060, 1, 0, 0, 0, 0);
        chk("imm_movi", bus.out_imm, 16'hFFFF);
        cyc(1, 16'h7800, 1, 0, 0, 0, 0);
        chk("imm_ldr", bus.out_imm, 16'hFFE0);
        idle(1, 0, 0);
        chk("imm_b", bus.out_imm, 16'hF800);
        idle(1, 1, 3'd2); idle(1, 1, 3'd0);

        // backpressure: output must stay frozen
        cyc(1, 16'h0A98, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h8098, 0, 0, 0, 0, 0);
            chk("bp_ready", bus.decode_ready, 0);
            chk("bp_hold", bus.out_instr, 16'h0A98);
        end
        cyc(1, 16'h8098, 1, 0, 0, 0, 0);
        chk("bp_release", bus.decode_ready, 1);
        idle(1, 0, 0);
        chk("bp_next", bus.out_instr, 16'h8098);
        idle(1, 1, 3'd5);

        // flush kills held ADD r5 without marking r5 busy
        cyc(1, 16'h0A98, 0, 0, 0, 0, 0);
        cyc(1, 16'h6140, 1, 1, 0, 0, 0);
        chk("flush_ready", bus.decode_ready, 0);
        cyc(1, 16'h6140, 1, 0, 0, 0, 0);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_no_busy", bus.decode_ready, 1);
        idle(1, 0, 0);

        // illegal opcode
        cyc(1, 16'hA000, 1, 0, 0, 0, 0);
        idle(1, 0, 0);
        chk("illegal", {bus.out_illegal, bus.out_writes_rd, bus.out_uses_rm, bus.out_uses_rn}, 4'b1000);

        // reset while stalled empties everything
        cyc(1, 16'h0298, 1, 0, 0, 0, 0);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        chk("pre_rst_stall", bus.stall_decode, 1);
        cyc(1, 16'h1850, 1, 0, 0, 0, 1);
        cyc(1, 16'h1850, 1, 0, 0, 0, 1);
        chk("mid_rst_fields", dut_vec(), 65'h0);
        chk("mid_rst_hs", {bus.out_valid, bus.decode_ready, bus.stall_decode}, 3'b000);
        cyc(1, 16'h1850, 1, 0, 0, 0, 0);
        chk("post_rst_ready", bus.decode_ready, 1);
        idle(1, 0, 0); idle(1, 1, 3'd4);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            ins = {4'($urandom_range(0, 15)), r[0], r[1], r[2], 3'($urandom_range(0, 7))};
            cyc($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                3'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
        end

        for (int i = 0; i < 4; i++) idle(1, 0, 0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
